// File: rtl/seq_alu.sv
// seq_alu: flow-controlled ALU; logic/shift/compare in one cycle, unsigned
// MUL (shift-add) and DIV (restoring) iterate one bit per cycle.
`default_nettype none

module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [4:0]         ALU_Select,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] ALU_Out,
  output logic               carry,
  output logic               zero,
  output logic               dbz,
  output logic               illegal
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_SLL  = 5'd4;
  localparam logic [4:0] OP_SRL  = 5'd5;
  localparam logic [4:0] OP_ROL  = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_AND  = 5'd8;
  localparam logic [4:0] OP_OR   = 5'd9;
  localparam logic [4:0] OP_XOR  = 5'd10;
  localparam logic [4:0] OP_NOR  = 5'd11;
  localparam logic [4:0] OP_NAND = 5'd12;
  localparam logic [4:0] OP_XNOR = 5'd13;
  localparam logic [4:0] OP_GT   = 5'd14;
  localparam logic [4:0] OP_EQ   = 5'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_out;
  logic                 r_carry;
  logic                 r_zero;
  logic                 r_dbz;
  logic                 r_illegal;
  logic [2*WIDTH-1:0]   r_p;
  logic [WIDTH-1:0]     r_opd;
  logic [SHW-1:0]       r_cnt;
  logic                 r_is_mul;
  logic                 r_fin;

  logic [SHW-1:0]       w_sh;
  logic [WIDTH:0]       w_add;
  logic [WIDTH:0]       w_sub;
  logic [2*WIDTH-1:0]   w_rotl;
  logic [2*WIDTH-1:0]   w_rotr;
  logic [2*WIDTH-1:0]   w_res;
  logic                 w_carry;
  logic                 w_dbz;
  logic                 w_ill;
  logic                 w_iter;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH:0]       w_div_diff;
  logic [2*WIDTH-1:0]   w_div_next;

  assign w_sh   = B[SHW-1:0];
  assign w_add  = {1'b0, A} + {1'b0, B};
  assign w_sub  = {1'b0, A} - {1'b0, B};
  // Rotates come from shifting a doubled copy of A and keeping one half.
  assign w_rotl = {A, A} << w_sh;
  assign w_rotr = {A, A} >> w_sh;
  assign w_iter = (ALU_Select == OP_MUL) || ((ALU_Select == OP_DIV) && (B != '0));

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_dbz   = 1'b0;
    w_ill   = 1'b0;
    case (ALU_Select)
      OP_ADD: begin
        w_res   = {{(WIDTH-1){1'b0}}, w_add};
        w_carry = w_add[WIDTH];
      end
      OP_SUB: begin
        w_res   = {{WIDTH{1'b0}}, w_sub[WIDTH-1:0]};
        w_carry = w_sub[WIDTH];
      end
      OP_MUL: w_res = '0;
      OP_DIV: begin
        w_res = {A, {WIDTH{1'b1}}};
        w_dbz = 1'b1;
      end
      OP_SLL:  w_res = {{WIDTH{1'b0}}, A << w_sh};
      OP_SRL:  w_res = {{WIDTH{1'b0}}, A >> w_sh};
      OP_ROL:  w_res = {{WIDTH{1'b0}}, w_rotl[2*WIDTH-1:WIDTH]};
      OP_ROR:  w_res = {{WIDTH{1'b0}}, w_rotr[WIDTH-1:0]};
      OP_AND:  w_res = {{WIDTH{1'b0}}, A & B};
      OP_OR:   w_res = {{WIDTH{1'b0}}, A | B};
      OP_XOR:  w_res = {{WIDTH{1'b0}}, A ^ B};
      OP_NOR:  w_res = {{WIDTH{1'b0}}, ~(A | B)};
      OP_NAND: w_res = {{WIDTH{1'b0}}, ~(A & B)};
      OP_XNOR: w_res = {{WIDTH{1'b0}}, ~(A ^ B)};
      OP_GT:   w_res = {{(2*WIDTH-1){1'b0}}, (A > B)};
      OP_EQ:   w_res = {{(2*WIDTH-1){1'b0}}, (A == B)};
      default: w_ill = 1'b1;
    endcase
  end

  // MUL: r_p = {partial, multiplier}; add multiplicand on LSB, shift right.
  assign w_mul_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_opd} : '0);
  assign w_mul_next = {w_mul_sum, r_p[WIDTH-1:1]};

  // DIV: r_p = {remainder, dividend/quotient}; quotient bits shift in at LSB.
  assign w_rem_sh   = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
  assign w_div_diff = w_rem_sh - {1'b0, r_opd};
  assign w_div_next = w_div_diff[WIDTH]
                    ? {w_rem_sh[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0}
                    : {w_div_diff[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_out     <= '0;
      r_carry   <= 1'b0;
      r_zero    <= 1'b0;
      r_dbz     <= 1'b0;
      r_illegal <= 1'b0;
      r_p       <= '0;
      r_opd     <= '0;
      r_cnt     <= '0;
      r_is_mul  <= 1'b0;
      r_fin     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_iter) begin
              r_is_mul <= (ALU_Select == OP_MUL);
              r_opd    <= (ALU_Select == OP_MUL) ? A : B;
              r_p      <= {{WIDTH{1'b0}}, (ALU_Select == OP_MUL) ? B : A};
              r_cnt    <= SHW'(WIDTH - 1);
              r_fin    <= 1'b0;
              r_state  <= S_BUSY;
            end else begin
              r_out     <= w_res;
              r_carry   <= w_carry;
              r_zero    <= (w_res == '0);
              r_dbz     <= w_dbz;
              r_illegal <= w_ill;
              r_state   <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          // One extra cycle after the last iteration publishes the result.
          if (r_fin) begin
            r_out     <= r_p;
            r_carry   <= 1'b0;
            r_zero    <= (r_p == '0);
            r_dbz     <= 1'b0;
            r_illegal <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            r_p <= r_is_mul ? w_mul_next : w_div_next;
            if (r_cnt == '0) begin
              r_fin <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign ALU_Out   = r_out;
  assign carry     = r_carry;
  assign zero      = r_zero;
  assign dbz       = r_dbz;
  assign illegal   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vector table plus reset/backpressure sequences for seq_alu.
`default_nettype none

module tb_seq_alu;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   A = '0;
  logic [W-1:0]   B = '0;
  logic [4:0]     sel = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] ALU_Out;
  logic           carry, zero, dbz, illegal;

  int total = 0;
  int bad = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALU_Select(sel), .out_valid(out_valid), .out_ready(out_ready),
    .ALU_Out(ALU_Out), .carry(carry), .zero(zero), .dbz(dbz), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] res;
    logic           c;
    logic           d;
    logic           il;
    int             lat;
    int             stall;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [2*W-1:0] res, input logic c, input logic d,
                              input logic il, input int lat, input int stall);
    vec_t t;
    t.op = op; t.a = a; t.b = b; t.res = res; t.c = c; t.d = d; t.il = il;
    t.lat = lat; t.stall = stall;
    vecs.push_back(t);
  endfunction

  task automatic do_op(input vec_t t);
    int n;
    int rdy_bad;
    string tag;
    tag = $sformatf("op%0d_a%h_b%h", t.op, t.a, t.b);
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_ready_in"}, 64'(in_ready), 64'd1);
    A = t.a; B = t.b; sel = t.op; in_valid = 1'b1;
    out_ready = (t.stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0; A = $urandom; B = $urandom; sel = 5'($urandom);
    n = 0; rdy_bad = 0;
    while (!out_valid && n < 200) begin
      if (in_ready) rdy_bad++;
      @(posedge clk); #1; n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(t.lat));
    chk({tag, "_ready_busy"}, 64'(rdy_bad), 64'd0);
    for (int s = 0; s <= t.stall; s++) begin
      chk({tag, "_out"}, ALU_Out, t.res);
      chk({tag, "_flags"}, {59'd0, out_valid, carry, zero, dbz, illegal},
          {59'd0, 1'b1, t.c, (t.res == '0), t.d, t.il});
      if (s < t.stall) begin
        A = $urandom; B = $urandom;
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_handshake"}, {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    // Spec test plan and corner cases.
    add(5'd0, 32'h0A, 32'h02, 64'h0C, 0, 0, 0, 0, 0);
    add(5'd0, 32'hFFFFFFFF, 32'h1, 64'h1_0000_0000, 1, 0, 0, 0, 0);
    add(5'd1, 32'h2, 32'h3, 64'h0000_0000_FFFF_FFFF, 1, 0, 0, 0, 0);
    add(5'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFF_FFFE_0000_0001, 0, 0, 0, 33, 0);
    add(5'd2, 32'h12345678, 32'h10, 64'h1_2345_6780, 0, 0, 0, 33, 2);
    add(5'd3, 32'hF6, 32'h0A, 64'h0000_0006_0000_0018, 0, 0, 0, 33, 0);
    add(5'd3, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 0, 0, 0, 33, 1);
    add(5'd3, 32'd5, 32'd7, 64'h0000_0005_0000_0000, 0, 0, 0, 33, 0);
    add(5'd3, 32'h1234, 32'h0, 64'h0000_1234_FFFF_FFFF, 0, 1, 0, 0, 0);
    add(5'd6, 32'h80000001, 32'h1, 64'h3, 0, 0, 0, 0, 0);
    add(5'd7, 32'h80000001, 32'h1, 64'hC000_0000, 0, 0, 0, 0, 0);
    add(5'd4, 32'h1, 32'h21, 64'h2, 0, 0, 0, 0, 0);
    add(5'd15, 32'h55, 32'h55, 64'h1, 0, 0, 0, 0, 0);
    add(5'd2, 32'h0, 32'h1234, 64'h0, 0, 0, 0, 33, 0);
    // Opcode sweep with A=0xF6, B=0x0A, 5-cycle stall per result.
    add(5'd0,  32'hF6, 32'h0A, 64'h100, 0, 0, 0, 0, 5);
    add(5'd1,  32'hF6, 32'h0A, 64'hEC, 0, 0, 0, 0, 5);
    add(5'd2,  32'hF6, 32'h0A, 64'h99C, 0, 0, 0, 33, 5);
    add(5'd3,  32'hF6, 32'h0A, 64'h0000_0006_0000_0018, 0, 0, 0, 33, 5);
    add(5'd4,  32'hF6, 32'h0A, 64'h3D800, 0, 0, 0, 0, 5);
    add(5'd5,  32'hF6, 32'h0A, 64'h0, 0, 0, 0, 0, 5);
    add(5'd6,  32'hF6, 32'h0A, 64'h3D800, 0, 0, 0, 0, 5);
    add(5'd7,  32'hF6, 32'h0A, 64'h3D80_0000, 0, 0, 0, 0, 5);
    add(5'd8,  32'hF6, 32'h0A, 64'h02, 0, 0, 0, 0, 5);
    add(5'd9,  32'hF6, 32'h0A, 64'hFE, 0, 0, 0, 0, 5);
    add(5'd10, 32'hF6, 32'h0A, 64'hFC, 0, 0, 0, 0, 5);
    add(5'd11, 32'hF6, 32'h0A, 64'hFFFF_FF01, 0, 0, 0, 0, 5);
    add(5'd12, 32'hF6, 32'h0A, 64'hFFFF_FFFD, 0, 0, 0, 0, 5);
    add(5'd13, 32'hF6, 32'h0A, 64'hFFFF_FF03, 0, 0, 0, 0, 5);
    add(5'd14, 32'hF6, 32'h0A, 64'h1, 0, 0, 0, 0, 5);
    add(5'd15, 32'hF6, 32'h0A, 64'h0, 0, 0, 0, 0, 5);
    for (int op = 16; op < 32; op++) add(5'(op), 32'hF6, 32'h0A, 64'h0, 0, 0, 1, 0, 5);

    #2 rst_n = 1'b0;
    #1;
    chk("reset_out", ALU_Out, 64'h0);
    chk("reset_flags", {58'd0, in_ready, out_valid, carry, zero, dbz, illegal}, {58'd0, 6'b100000});
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[i]) do_op(vecs[i]);

    // Reset in the middle of a multiply.
    @(negedge clk);
    A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; sel = 5'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("midmul_reset", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
    chk("midmul_reset_out", ALU_Out, 64'h0);
    @(negedge clk) rst_n = 1'b1;
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    chk("midmul_no_result", 64'(n), 64'd0);
    do_op(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
